ift_trace_recorder: RTL and testbench
=====================================

// Module: ift_trace_recorder
// PURPOSE
//  Sink-side counterpart to the IFT stimulus path. Samples a DUT output value and its
//  taint vector (e.g. Q/Q_t of a latch or flop under test) every clock and stores only
//  changed samples in a circular trace buffer. A bench or host drains entries over a
//  valid/ready read port. Sits beside the DUT in IFT flip-flop/latch test harnesses.
// PARAMETERS
//  DATA_W   2    width of observed data value
//  TAINT_W  32   width of observed taint vector
//  DEPTH    16   trace entries; power of two, >=2
// PORTS
//  clk       in   1        single clock, rising edge
//  rst_n     in   1        synchronous reset, active low
//  start     in   1        pulse: IDLE/STOPPED -> ARMED
//  stop      in   1        pulse: any state -> IDLE, buffer kept
//  clear     in   1        pulse: flush buffer, clear overflow, -> IDLE
//  trig_taint in  1        1: arm waits for t_in!=0; 0: trigger on first armed cycle
//  d_in      in   DATA_W   observed value
//  t_in      in   TAINT_W  observed taint
//  rd_valid  out  1        head entry available (=!empty)
//  rd_ready  in   1        consumer accepts head entry
//  rd_data   out  DATA_W   head entry value
//  rd_taint  out  TAINT_W  head entry taint
//  count     out  $clog2(DEPTH)+1  entries stored
//  full      out  1        count==DEPTH
//  overflow  out  1        sticky: a change was dropped
//  state     out  2        IDLE=0 ARMED=1 RECORD=2 STOPPED=3
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=IDLE, count=0, wr/rd ptr=0, overflow=0,
//    last-sample reg=0, rd_data/rd_taint=0, rd_valid=0, timestamp=0.
//  - Priority per cycle: reset > clear > stop > start > capture logic.
//  - IDLE: no writes. start -> ARMED.
//  - ARMED: trigger = trig_taint ? (t_in!=0) : 1. On trigger write {d_in,t_in}
//    unconditionally, load last-sample reg, -> RECORD (same edge).
//  - RECORD: write when {d_in,t_in} != last-sample reg; update last-sample on write.
//    Identical samples never stored (change compression).
//  - Write accepted if !full OR pop same cycle (push+pop when full: count stays DEPTH).
//  - Change while full and no pop: sample dropped, overflow<=1, -> STOPPED.
//  - STOPPED: no writes; reads continue. start -> ARMED (overflow kept), clear -> IDLE.
//  - Pop = rd_valid & rd_ready; rd ptr advances, count-1. rd_data/rd_taint are
//    combinational from head entry; 0 when empty. Pop when empty ignored.
//  - Push and pop same cycle: count unchanged. Pointers wrap modulo DEPTH.
//  - Write latency: sample at edge N visible at rd_* after edge N if buffer was empty.
//  - clear mid-read: pointers/count to 0 at that edge; rd_valid=0 next cycle.
//  - stop in RECORD: pending same-cycle sample is not written.
// CONFIGURATION
//  TRACE_TIMESTAMP_EN defined: free-running 16-bit cycle counter (reset 0, wraps
//    0xFFFF->0) stored with every entry; extra port rd_ts out 16 = head entry stamp
//    (0 when empty). Counter runs in all states.
//  Undefined: no counter, no rd_ts port; entries hold data+taint only.
// TESTING
//  1 reset, start, trig_taint=0, d_in=2'b01 t_in=0 held 5 cycles -> exactly 1 entry
//    {01,0}, count=1, state=RECORD.
//  2 trig_taint=1, t_in=0 for 4 cycles then t_in=32'h1 -> ARMED until t_in!=0; first
//    entry taint=32'h1.
//  3 DEPTH=16, rd_ready=0, d_in walks 00,01,10,11,... 17 changes -> count=16, full=1,
//    overflow=1, state=STOPPED; 17th value absent when drained.
//  4 full buffer, rd_ready=1 while new change arrives -> entry accepted, count=16,
//    overflow=0, order preserved (FIFO).
//  5 clear while rd_valid=1 count=5 -> next cycle count=0, rd_valid=0, state=IDLE.
//  6 with TRACE_TIMESTAMP_EN: trigger at cycle 10 after reset, change at cycle 13 ->
//    rd_ts 10 then 13; counter wrap at 65535->0 stamps 0.

Source files
------------

// File: rtl/ift_trace_recorder.sv
// ift_trace_recorder: change-compressed trace sink for IFT flop/latch harnesses.
// Each clock it samples {d_in, t_in}. A sample is stored in a circular buffer
// only when it differs from the last stored sample. The first sample after
// the trigger is always stored. Entries are drained through a valid/ready port.
// Optional feature: define TRACE_TIMESTAMP_EN to add a free-running 16-bit
// cycle stamp to every entry and expose it on rd_ts.
module ift_trace_recorder #(
  parameter int DATA_W  = 2,
  parameter int TAINT_W = 32,
  parameter int DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     clear,
  input  logic                     trig_taint,
  input  logic [DATA_W-1:0]        d_in,
  input  logic [TAINT_W-1:0]       t_in,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_W-1:0]        rd_data,
  output logic [TAINT_W-1:0]       rd_taint,
`ifdef TRACE_TIMESTAMP_EN
  output logic [15:0]              rd_ts,
`endif
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow,
  output logic [1:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = DATA_W + TAINT_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_RECORD  = 2'd2,
    S_STOPPED = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0]  d;
    logic [TAINT_W-1:0] t;
`ifdef TRACE_TIMESTAMP_EN
    logic [15:0]        ts;
`endif
  } entry_t;

  state_t         st;
  entry_t         mem [DEPTH];
  entry_t         head;
  entry_t         wr_entry;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  cnt;
  logic [SW-1:0]  last, cur;
  logic           ovf;
  logic           trig, want, want_wr, push, pop, drop;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0]    ts;
`endif

  assign cur      = {d_in, t_in};
  assign rd_valid = (cnt != '0);
  assign full     = (cnt == DEPTH_C);
  assign count    = cnt;
  assign overflow = ovf;
  assign state    = st;
  assign head     = mem[rd_ptr];

  // Head entry is shown directly; it is forced to zero while the buffer is empty.
  always_comb begin
    rd_data  = '0;
    rd_taint = '0;
`ifdef TRACE_TIMESTAMP_EN
    rd_ts    = '0;
`endif
    if (rd_valid) begin
      rd_data  = head.d;
      rd_taint = head.t;
`ifdef TRACE_TIMESTAMP_EN
      rd_ts    = head.ts;
`endif
    end
  end

  // Capture decision. Clear and stop suppress any same-cycle sample.
  // When full, a push is accepted only if a pop frees the head slot in the same cycle.
  always_comb begin
    trig    = trig_taint ? (|t_in) : 1'b1;
    want    = ((st == S_ARMED) && trig) || ((st == S_RECORD) && (cur != last));
    want_wr = rst_n && !clear && !stop && want;
    pop     = rd_valid && rd_ready;
    push    = want_wr && (!full || pop);
    drop    = want_wr && full && !pop;
    wr_entry.d  = d_in;
    wr_entry.t  = t_in;
`ifdef TRACE_TIMESTAMP_EN
    wr_entry.ts = ts;
`endif
  end

  // Trace storage. This block needs no reset because reads are gated by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

`ifdef TRACE_TIMESTAMP_EN
  // Free-running cycle stamp. It runs in every state and wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) ts <= '0;
    else        ts <= ts + 16'd1;
  end
`endif

  // Control FSM, pointers and occupancy. Priority: reset > clear > stop > start > capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st     <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      last   <= '0;
    end else if (clear) begin
      st     <= S_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        last   <= cur;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop) ovf <= 1'b1;

      if (stop) begin
        st <= S_IDLE;
      end else if (start && (st == S_IDLE || st == S_STOPPED)) begin
        st <= S_ARMED;
      end else begin
        case (st)
          S_ARMED:  if (drop) st <= S_STOPPED;
                    else if (push) st <= S_RECORD;
          S_RECORD: if (drop) st <= S_STOPPED;
          default:  st <= st;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ift_trace_recorder.sv
// Directed bench for ift_trace_recorder. It applies a vector table for the
// trigger and compression cases. Hand sequences cover overflow, push/pop at
// full, clear during a read and, when enabled, the timestamps.
module tb_ift_trace_recorder;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, clear, trig_taint, rd_ready;
  logic [1:0]  d_in;
  logic [31:0] t_in;
  logic        rd_valid, full, overflow;
  logic [1:0]  rd_data, state;
  logic [31:0] rd_taint;
  logic [4:0]  count;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0] rd_ts;
`endif

  int total = 0;
  int bad   = 0;
  int k     = 0;   // edges since the reset edge = stamp for the next edge

  always #5 clk = ~clk;

  ift_trace_recorder #(.DATA_W(2), .TAINT_W(32), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
    .trig_taint(trig_taint), .d_in(d_in), .t_in(t_in),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_taint(rd_taint),
`ifdef TRACE_TIMESTAMP_EN
    .rd_ts(rd_ts),
`endif
    .count(count), .full(full), .overflow(overflow), .state(state)
  );

  typedef struct {
    logic        start, stop, clear, trig;
    logic [1:0]  d;
    logic [31:0] t;
    logic        rdy;
    logic [4:0]  e_cnt;
    logic [1:0]  e_st;
    logic        e_vld;
    logic [1:0]  e_d;
    logic [31:0] e_t;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(logic s, logic p, logic c, logic tr, logic [1:0] d,
                              logic [31:0] t, logic r, logic [4:0] ec, logic [1:0] es,
                              logic ev, logic [1:0] ed, logic [31:0] et);
    vec_t v;
    v.start = s; v.stop = p; v.clear = c; v.trig = tr; v.d = d; v.t = t; v.rdy = r;
    v.e_cnt = ec; v.e_st = es; v.e_vld = ev; v.e_d = ed; v.e_t = et;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    k = rst_n ? k + 1 : 0;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 0; stop = 0; clear = 0; trig_taint = 0;
    rd_ready = 0; d_in = 0; t_in = 0;

    // Vector table. Columns: start stop clear trig d t rdy | count state valid data taint
    tbl[0]  = mk(1,0,0,0, 2'd0, 0, 0,  5'd0, 2'd1, 0, 2'd0, 0);
    tbl[1]  = mk(0,0,0,0, 2'd1, 0, 0,  5'd1, 2'd2, 1, 2'd1, 0);
    tbl[2]  = mk(0,0,0,0, 2'd1, 0, 0,  5'd1, 2'd2, 1, 2'd1, 0);
    tbl[3]  = mk(0,0,0,0, 2'd1, 0, 0,  5'd1, 2'd2, 1, 2'd1, 0);
    tbl[4]  = mk(0,0,0,0, 2'd1, 0, 0,  5'd1, 2'd2, 1, 2'd1, 0);
    tbl[5]  = mk(0,0,0,0, 2'd1, 0, 0,  5'd1, 2'd2, 1, 2'd1, 0);
    tbl[6]  = mk(0,1,0,0, 2'd1, 0, 0,  5'd1, 2'd0, 1, 2'd1, 0);
    tbl[7]  = mk(0,0,0,0, 2'd1, 0, 1,  5'd0, 2'd0, 0, 2'd0, 0);
    tbl[8]  = mk(1,0,0,1, 2'd0, 0, 0,  5'd0, 2'd1, 0, 2'd0, 0);
    tbl[9]  = mk(0,0,0,1, 2'd0, 0, 0,  5'd0, 2'd1, 0, 2'd0, 0);
    tbl[10] = mk(0,0,0,1, 2'd0, 0, 0,  5'd0, 2'd1, 0, 2'd0, 0);
    tbl[11] = mk(0,0,0,1, 2'd0, 0, 0,  5'd0, 2'd1, 0, 2'd0, 0);
    tbl[12] = mk(0,0,0,1, 2'd0, 0, 0,  5'd0, 2'd1, 0, 2'd0, 0);
    tbl[13] = mk(0,0,0,1, 2'd2, 1, 0,  5'd1, 2'd2, 1, 2'd2, 1);
    tbl[14] = mk(0,0,0,1, 2'd2, 1, 0,  5'd1, 2'd2, 1, 2'd2, 1);
    tbl[15] = mk(0,0,0,1, 2'd3, 1, 0,  5'd2, 2'd2, 1, 2'd2, 1);
    tbl[16] = mk(0,0,0,1, 2'd3, 1, 1,  5'd1, 2'd2, 1, 2'd3, 1);
    tbl[17] = mk(0,1,0,1, 2'd3, 1, 1,  5'd0, 2'd0, 0, 2'd0, 0);

    // Reset state
    step();
    chk("rst_state", 32'(state), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_data", 32'(rd_data), 0);
    chk("rst_taint", rd_taint, 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst_n = 1'b1;

    // Table: immediate trigger with compression, then a taint-gated trigger
    for (int i = 0; i < 18; i++) begin
      start = tbl[i].start; stop = tbl[i].stop; clear = tbl[i].clear;
      trig_taint = tbl[i].trig; d_in = tbl[i].d; t_in = tbl[i].t; rd_ready = tbl[i].rdy;
      step();
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("v%0d_state", i), 32'(state), 32'(tbl[i].e_st));
      chk($sformatf("v%0d_valid", i), 32'(rd_valid), 32'(tbl[i].e_vld));
      chk($sformatf("v%0d_data", i), 32'(rd_data), 32'(tbl[i].e_d));
      chk($sformatf("v%0d_taint", i), rd_taint, tbl[i].e_t);
    end
    start = 0; stop = 0; rd_ready = 0; trig_taint = 0;

    // Overflow: 17 changes into 16 slots, nothing read
    clear = 1; step(); clear = 0;
    chk("ovf_clr_state", 32'(state), 0);
    start = 1; d_in = 0; t_in = 0; step(); start = 0;
    for (int i = 0; i < 17; i++) begin
      d_in = 2'(i); t_in = 32'(i); step();
    end
    chk("ovf_count", 32'(count), 16);
    chk("ovf_full", 32'(full), 1);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_state", 32'(state), 3);
    rd_ready = 1;
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("ovf_drain%0d_data", j), 32'(rd_data), 32'(j % 4));
      chk($sformatf("ovf_drain%0d_taint", j), rd_taint, 32'(j));
      step();
    end
    rd_ready = 0;
    chk("ovf_empty", 32'(rd_valid), 0);
    start = 1; step(); start = 0;
    chk("restart_state", 32'(state), 1);
    chk("restart_ovf_kept", 32'(overflow), 1);

    // Push and pop in the same cycle while full: nothing is lost and order holds
    clear = 1; step(); clear = 0;
    chk("pp_ovf_cleared", 32'(overflow), 0);
    start = 1; step(); start = 0;
    for (int i = 0; i < 16; i++) begin
      d_in = 2'(i); t_in = 32'(100 + i); step();
    end
    chk("pp_full", 32'(full), 1);
    d_in = 2'd0; t_in = 32'd116; rd_ready = 1; step(); rd_ready = 0;
    chk("pp_count", 32'(count), 16);
    chk("pp_ovf", 32'(overflow), 0);
    chk("pp_state", 32'(state), 2);
    chk("pp_head", rd_taint, 101);
    stop = 1; step(); stop = 0;
    rd_ready = 1;
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("pp_drain%0d_taint", j), rd_taint, 32'(101 + j));
      chk($sformatf("pp_drain%0d_data", j), 32'(rd_data), 32'((j + 1) % 4));
      step();
    end
    rd_ready = 0;
    chk("pp_empty", 32'(count), 0);

    // Clear while 5 entries are pending and a read is in progress
    clear = 1; step(); clear = 0;
    start = 1; step(); start = 0;
    for (int i = 0; i < 5; i++) begin
      d_in = 2'(i); t_in = 32'(200 + i); step();
    end
    chk("clr_pre_count", 32'(count), 5);
    chk("clr_pre_valid", 32'(rd_valid), 1);
    clear = 1; rd_ready = 1; step(); clear = 0; rd_ready = 0;
    chk("clr_count", 32'(count), 0);
    chk("clr_valid", 32'(rd_valid), 0);
    chk("clr_state", 32'(state), 0);
    chk("clr_taint", rd_taint, 0);

`ifdef TRACE_TIMESTAMP_EN
    // Stamps: trigger when the counter reads 10, change when it reads 13, then the wrap
    rst_n = 0; d_in = 0; t_in = 0; step(); rst_n = 1;
    chk("ts_empty", 32'(rd_ts), 0);
    trig_taint = 1; start = 1; step(); start = 0;
    while (k < 10) step();
    t_in = 32'd1; step();
    step(); step();
    d_in = 2'd1; step();
    chk("ts_first", 32'(rd_ts), 10);
    rd_ready = 1; step();
    chk("ts_second", 32'(rd_ts), 13);
    step(); rd_ready = 0;
    stop = 1; step(); stop = 0;
    while (k < 65534) step();
    trig_taint = 0; start = 1; step(); start = 0;
    step();
    d_in = 2'd2; step();
    chk("ts_pre_wrap", 32'(rd_ts), 32'hFFFF);
    rd_ready = 1; step(); rd_ready = 0;
    chk("ts_wrap", 32'(rd_ts), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
